xc_malu_issue: RTL and testbench
================================

Name: xc_malu_issue

Overview:
Issue and sequencing front-end for the multi-cycle arithmetic unit. It accepts one decoded instruction per transaction from the execute stage over a valid/ready handshake and registers the operands. It then converts the opcode to one-hot uop strobes and pack-width strobes, and holds the unit's valid input until the unit raises ready. It captures the 64-bit result, pulses flush to return the unit to its init state, and presents the result to writeback over a second valid/ready handshake. It also provides kill and abort, illegal-opcode rejection and a watchdog timeout.

Parameters:
TIMEOUT, 96, maximum cycles in BUSY before an error response is forced; must be >= 2.
CNT_W, 7, width of the busy-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clock  in  1  single clock; all state on its rising edge.
resetn  in  1  asynchronous, active-low reset.
in_valid  in  1  instruction offered.
in_ready  out  1  issue accepts an instruction this cycle.
in_op  in  4  0 div, 1 divu, 2 rem, 3 remu, 4 mul, 5 mulu, 6 mulsu, 7 clmul, 8 pmul, 9 pclmul, 10 madd, 11 msub, 12 macc, 13 mmul; 14–15 illegal.
in_pw  in  3  pack width: 0=32, 1=16, 2=8, 3=4, 4=2; 5–7 illegal.
in_rs1, in_rs2, in_rs3  in  32 each  source operands.
in_tag  in  5  destination tag, returned unchanged.
kill  in  1  abort any in-flight transaction.
m_rs1, m_rs2, m_rs3  out  32 each  registered operands to the unit.
m_uop  out  14  one-hot uop strobes, bit n = opcode n.
m_pw  out  5  {pw_2, pw_4, pw_8, pw_16, pw_32}, one-hot.
m_valid  out  1  unit inputs valid.
m_flush  out  1  unit flush.
m_result  in  64  unit result.
m_ready  in  1  unit result ready.
out_valid  out  1  response available.
out_ready  in  1  writeback accepts the response.
out_result  out  64  captured result.
out_tag  out  5  tag of the response.
out_err  out  2  0 ok, 1 illegal op or pw, 2 timeout.

Behaviour:
- States: IDLE, BUSY, FLUSH, RESP. Reset enters IDLE.
- Reset values: all outputs 0 except in_ready=1. Operand, uop, result and tag registers are cleared.
- in_ready is 1 only in IDLE and depends on no input.
- IDLE, on in_valid:
  - Legal op and pw: register operands, tag, m_uop and m_pw; clear the counter; go to BUSY. m_valid rises on the next cycle, so acceptance-to-m_valid latency is 1 cycle.
  - Illegal op or pw: no unit activity; out_err=1, out_result=0, out_valid=1 next cycle; go to RESP.
- BUSY:
  - m_valid=1. Operands, m_uop and m_pw are held stable for the whole BUSY period.
  - Counter increments each cycle.
  - On m_ready=1: capture m_result into out_result, set out_err=0 and out_valid=1, go to FLUSH.
  - Else if counter == TIMEOUT-1: out_err=2, out_result=0, out_valid=1, go to FLUSH.
  - m_ready is sampled only while in BUSY.
- FLUSH (exactly 1 cycle):
  - m_flush=1, m_valid=0, m_uop=0.
  - out_valid remains 1. If out_ready=1 this cycle, the response is consumed and the next state is IDLE; otherwise RESP.
- RESP:
  - m_valid=0, m_flush=0.
  - out_valid, out_result, out_tag and out_err are held stable until out_ready=1, then go to IDLE.
- Handshake:
  - Response completes on out_valid&&out_ready.
  - Minimum turnaround is 1 extra cycle after a response completes, then IDLE accepts again. There is no back-to-back overlap.
- kill:
  - In BUSY: next state is FLUSH with out_valid forced 0, then IDLE; no response is generated.
  - In FLUSH or RESP: out_valid drops next cycle, the pending response is discarded, go to IDLE. m_flush still completes its single pulse if in FLUSH.
  - In IDLE: kill blocks acceptance that cycle (in_ready stays 1, but the transfer is ignored).
  - kill has priority over m_ready and timeout in the same cycle.
- Simultaneous m_ready and timeout in the same cycle: m_ready wins, out_err=0.
- Asynchronous reset mid-transaction: immediate return to reset values. The unit is not flushed by this block; unit reset is shared.

Test Plan:
- mulu, rs1=0xFFFFFFFF, rs2=2, stub unit returns 0x00000001_FFFFFFFE after 33 cycles -> m_uop=0x0020, m_pw=0x01; out_result=0x00000001_FFFFFFFE, out_err=0; m_flush one cycle after m_ready.
- divu, tag=0x11, out_ready held 0 for 5 cycles after response -> out_valid, result and tag stable across the stall; in_ready=0 until the cycle after the response handshake.
- in_op=14 or in_pw=6 -> out_err=1 and out_valid 1 cycle after accept; m_valid never asserts.
- Stub never raises m_ready, TIMEOUT=96 -> out_err=2 with out_valid after 96 BUSY cycles; single m_flush pulse.
- kill asserted on cycle 10 of BUSY, m_ready on the same cycle -> no out_valid, one m_flush, back in IDLE 2 cycles later; next pmul (pw=1) issues normally with m_pw=0x02.
- resetn deasserted mid-BUSY -> all outputs at reset values immediately; in_ready=1 once reset is released.

Source files
------------

// File: rtl/xc_malu_issue.sv
// xc_malu_issue: issue and sequencing front-end for the multi-cycle
// arithmetic unit. It accepts one instruction at a time, drives the unit with
// registered operands and one-hot strobes, waits for the result (bounded by a
// watchdog), flushes the unit and returns the response to writeback.
module xc_malu_issue #(
  parameter int TIMEOUT = 96,
  parameter int CNT_W   = 7
) (
  input  logic         clock,
  input  logic         resetn,
  // execute-stage request
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [2:0]   in_pw,
  input  logic [31:0]  in_rs1,
  input  logic [31:0]  in_rs2,
  input  logic [31:0]  in_rs3,
  input  logic [4:0]   in_tag,
  input  logic         kill,
  // arithmetic unit side
  output logic [31:0]  m_rs1,
  output logic [31:0]  m_rs2,
  output logic [31:0]  m_rs3,
  output logic [13:0]  m_uop,
  output logic [4:0]   m_pw,
  output logic         m_valid,
  output logic         m_flush,
  input  logic [63:0]  m_result,
  input  logic         m_ready,
  // writeback response
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_result,
  output logic [4:0]   out_tag,
  output logic [1:0]   out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  state_t state;
  state_t state_nxt;

  logic [31:0]      rs1_q;
  logic [31:0]      rs2_q;
  logic [31:0]      rs3_q;
  logic [13:0]      uop_q;
  logic [4:0]       pw_q;
  logic [4:0]       tag_q;
  logic [63:0]      result_q;
  logic [1:0]       err_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic op_legal;
  logic pw_legal;
  logic accept;
  logic accept_legal;
  logic accept_illegal;
  logic timeout_hit;
  logic leave_busy;
  logic resp_drop;

  // Opcodes 14-15 and pack widths 5-7 have no unit encoding.
  assign op_legal = (in_op <= 4'd13);
  assign pw_legal = (in_pw <= 3'd4);

  // A kill in IDLE suppresses the transfer even though in_ready stays high.
  assign accept         = (state == IDLE) && in_valid && !kill;
  assign accept_legal   = accept && op_legal && pw_legal;
  assign accept_illegal = accept && !(op_legal && pw_legal);

  assign timeout_hit = (cnt_q == CNT_LAST);
  assign leave_busy  = (state == BUSY) && (kill || m_ready || timeout_hit);

  // A pending response disappears on a kill or once writeback takes it.
  assign resp_drop = ((state == FLUSH) || (state == RESP)) && (kill || out_ready);

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; kill outranks m_ready, which outranks the watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_legal) begin
          state_nxt = BUSY;
        end else if (accept_illegal) begin
          state_nxt = RESP;
        end
      end
      BUSY: begin
        if (leave_busy) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (kill || !out_valid_q || out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (kill || out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded handshake and unit control outputs.
  always_comb begin
    in_ready = 1'b0;
    m_valid  = 1'b0;
    m_flush  = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      BUSY:    m_valid  = 1'b1;
      FLUSH:   m_flush  = 1'b1;
      default: ;
    endcase
  end

  // Operand, pack-width and tag capture; held untouched while the unit works.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rs1_q <= '0;
      rs2_q <= '0;
      rs3_q <= '0;
      pw_q  <= '0;
      tag_q <= '0;
    end else begin
      if (accept) begin
        tag_q <= in_tag;
      end
      if (accept_legal) begin
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        rs3_q <= in_rs3;
        pw_q  <= 5'(5'd1 << in_pw);
      end
    end
  end

  // One-hot uop strobes live only for the BUSY period and drop with the flush.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      uop_q <= '0;
    end else if (accept_legal) begin
      uop_q <= 14'(14'd1 << in_op);
    end else if (leave_busy) begin
      uop_q <= '0;
    end
  end

  // Watchdog counter: starts at zero on issue and counts every BUSY cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (accept_legal) begin
      cnt_q <= '0;
    end else if (state == BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Response register: filled by illegal rejection, unit result or timeout.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= ERR_OK;
    end else begin
      if (accept_illegal) begin
        out_valid_q <= 1'b1;
        result_q    <= '0;
        err_q       <= ERR_ILLEGAL;
      end else if ((state == BUSY) && !kill) begin
        if (m_ready) begin
          out_valid_q <= 1'b1;
          result_q    <= m_result;
          err_q       <= ERR_OK;
        end else if (timeout_hit) begin
          out_valid_q <= 1'b1;
          result_q    <= '0;
          err_q       <= ERR_TIMEOUT;
        end
      end else if (resp_drop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign m_rs1      = rs1_q;
  assign m_rs2      = rs2_q;
  assign m_rs3      = rs3_q;
  assign m_uop      = uop_q;
  assign m_pw       = pw_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_xc_malu_issue.sv
// Directed testbench for xc_malu_issue: the unit is played by the stimulus
// sequence itself, and every expected value is written out by hand.
module tb_xc_malu_issue;

  logic         clock;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [2:0]   in_pw;
  logic [31:0]  in_rs1;
  logic [31:0]  in_rs2;
  logic [31:0]  in_rs3;
  logic [4:0]   in_tag;
  logic         kill;
  logic [31:0]  m_rs1;
  logic [31:0]  m_rs2;
  logic [31:0]  m_rs3;
  logic [13:0]  m_uop;
  logic [4:0]   m_pw;
  logic         m_valid;
  logic         m_flush;
  logic [63:0]  m_result;
  logic         m_ready;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_result;
  logic [4:0]   out_tag;
  logic [1:0]   out_err;

  int compared   = 0;
  int mismatched = 0;

  xc_malu_issue #(.TIMEOUT(96), .CNT_W(7)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_pw      (in_pw),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rs3     (in_rs3),
    .in_tag     (in_tag),
    .kill       (kill),
    .m_rs1      (m_rs1),
    .m_rs2      (m_rs2),
    .m_rs3      (m_rs3),
    .m_uop      (m_uop),
    .m_pw       (m_pw),
    .m_valid    (m_valid),
    .m_flush    (m_flush),
    .m_result   (m_result),
    .m_ready    (m_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=stalled expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one instruction on the request port.
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] pw,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] rs3, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_pw    = pw;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rs3   = rs3;
    in_tag   = tag;
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_pw     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rs3    = '0;
    in_tag    = '0;
    kill      = 1'b0;
    m_result  = '0;
    m_ready   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    tick();
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_flush", m_flush, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_m_uop", m_uop, 0);
    checkOutput("rst_out_result", out_result, 0);
    tick();
    resetn = 1'b1;
    tick();

    // mulu with a 33-cycle unit
    applyStimulus(4'd5, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd3);
    tick();
    in_valid = 1'b0;
    checkOutput("mulu_m_valid", m_valid, 1);
    checkOutput("mulu_m_uop", m_uop, 14'h0020);
    checkOutput("mulu_m_pw", m_pw, 5'h01);
    checkOutput("mulu_m_rs1", m_rs1, 32'hFFFF_FFFF);
    checkOutput("mulu_m_rs2", m_rs2, 32'd2);
    checkOutput("mulu_in_ready", in_ready, 0);
    repeat (32) tick();
    checkOutput("mulu_busy33_valid", m_valid, 1);
    checkOutput("mulu_busy33_uop", m_uop, 14'h0020);
    checkOutput("mulu_busy33_out_valid", out_valid, 0);
    m_ready  = 1'b1;
    m_result = 64'h0000_0001_FFFF_FFFE;
    tick();
    m_ready  = 1'b0;
    m_result = 64'h0;
    checkOutput("mulu_flush", m_flush, 1);
    checkOutput("mulu_flush_m_valid", m_valid, 0);
    checkOutput("mulu_flush_m_uop", m_uop, 0);
    checkOutput("mulu_out_valid", out_valid, 1);
    checkOutput("mulu_out_result", out_result, 64'h0000_0001_FFFF_FFFE);
    checkOutput("mulu_out_err", out_err, 0);
    checkOutput("mulu_out_tag", out_tag, 5'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("mulu_done_in_ready", in_ready, 1);
    checkOutput("mulu_done_out_valid", out_valid, 0);
    checkOutput("mulu_done_flush", m_flush, 0);

    // divu with a stalled writeback
    applyStimulus(4'd1, 3'd0, 32'd100, 32'd7, 32'd0, 5'h11);
    tick();
    in_valid = 1'b0;
    checkOutput("divu_m_uop", m_uop, 14'h0002);
    m_ready  = 1'b1;
    m_result = 64'h0000_0000_0000_000E;
    tick();
    m_ready  = 1'b0;
    checkOutput("divu_flush", m_flush, 1);
    checkOutput("divu_out_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("divu_stall_valid", out_valid, 1);
      checkOutput("divu_stall_result", out_result, 64'h0000_0000_0000_000E);
      checkOutput("divu_stall_tag", out_tag, 5'h11);
      checkOutput("divu_stall_in_ready", in_ready, 0);
      checkOutput("divu_stall_flush", m_flush, 0);
    end
    out_ready = 1'b1;
    checkOutput("divu_hs_in_ready", in_ready, 0);
    tick();
    out_ready = 1'b0;
    checkOutput("divu_after_in_ready", in_ready, 1);
    checkOutput("divu_after_out_valid", out_valid, 0);

    // Illegal opcode
    applyStimulus(4'd14, 3'd0, 32'd1, 32'd1, 32'd1, 5'd5);
    tick();
    in_valid = 1'b0;
    checkOutput("ill_op_out_valid", out_valid, 1);
    checkOutput("ill_op_out_err", out_err, 1);
    checkOutput("ill_op_out_result", out_result, 0);
    checkOutput("ill_op_out_tag", out_tag, 5'd5);
    checkOutput("ill_op_m_valid", m_valid, 0);
    checkOutput("ill_op_m_flush", m_flush, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("ill_op_done", in_ready, 1);

    // Illegal pack width
    applyStimulus(4'd4, 3'd6, 32'd1, 32'd1, 32'd1, 5'd6);
    tick();
    in_valid = 1'b0;
    checkOutput("ill_pw_out_valid", out_valid, 1);
    checkOutput("ill_pw_out_err", out_err, 1);
    checkOutput("ill_pw_m_valid", m_valid, 0);
    checkOutput("ill_pw_m_uop", m_uop, 0);
    // kill discards the pending response from RESP
    kill = 1'b1;
    tick();
    kill = 1'b0;
    checkOutput("ill_pw_kill_out_valid", out_valid, 0);
    checkOutput("ill_pw_kill_in_ready", in_ready, 1);

    // kill in IDLE blocks acceptance
    applyStimulus(4'd4, 3'd0, 32'd3, 32'd4, 32'd0, 5'd7);
    kill = 1'b1;
    tick();
    kill     = 1'b0;
    in_valid = 1'b0;
    checkOutput("idle_kill_m_valid", m_valid, 0);
    checkOutput("idle_kill_in_ready", in_ready, 1);
    checkOutput("idle_kill_out_valid", out_valid, 0);

    // Watchdog timeout with a unit that never answers
    applyStimulus(4'd4, 3'd0, 32'd9, 32'd9, 32'd0, 5'd8);
    tick();
    in_valid = 1'b0;
    repeat (95) tick();
    checkOutput("to_busy96_m_valid", m_valid, 1);
    checkOutput("to_busy96_out_valid", out_valid, 0);
    tick();
    checkOutput("to_flush", m_flush, 1);
    checkOutput("to_out_valid", out_valid, 1);
    checkOutput("to_out_err", out_err, 2);
    checkOutput("to_out_result", out_result, 0);
    tick();
    checkOutput("to_resp_flush", m_flush, 0);
    checkOutput("to_resp_valid", out_valid, 1);
    checkOutput("to_resp_err", out_err, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("to_done", in_ready, 1);

    // kill on BUSY cycle 10 together with m_ready
    applyStimulus(4'd12, 3'd0, 32'd1, 32'd2, 32'd3, 5'd9);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    kill     = 1'b1;
    m_ready  = 1'b1;
    m_result = 64'hDEAD_BEEF_0000_0001;
    tick();
    kill    = 1'b0;
    m_ready = 1'b0;
    checkOutput("kill_flush", m_flush, 1);
    checkOutput("kill_out_valid", out_valid, 0);
    checkOutput("kill_m_valid", m_valid, 0);
    tick();
    checkOutput("kill_idle", in_ready, 1);
    checkOutput("kill_idle_out_valid", out_valid, 0);
    checkOutput("kill_idle_flush", m_flush, 0);

    // pmul, pw=16 after the kill
    applyStimulus(4'd8, 3'd1, 32'h1234_5678, 32'h0001_0002, 32'd0, 5'd10);
    tick();
    in_valid = 1'b0;
    checkOutput("pmul_m_uop", m_uop, 14'h0100);
    checkOutput("pmul_m_pw", m_pw, 5'h02);
    checkOutput("pmul_m_valid", m_valid, 1);
    m_ready  = 1'b1;
    m_result = 64'h0000_0000_1234_ACF0;
    out_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("pmul_out_result", out_result, 64'h0000_0000_1234_ACF0);
    checkOutput("pmul_out_tag", out_tag, 5'd10);
    tick();
    out_ready = 1'b0;
    checkOutput("pmul_done", in_ready, 1);

    // Asynchronous reset in the middle of BUSY
    applyStimulus(4'd6, 3'd2, 32'hAAAA_5555, 32'h0F0F_0F0F, 32'd0, 5'd12);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checkOutput("arst_pre_m_valid", m_valid, 1);
    resetn = 1'b0;
    #1;
    checkOutput("arst_m_valid", m_valid, 0);
    checkOutput("arst_in_ready", in_ready, 1);
    checkOutput("arst_m_uop", m_uop, 0);
    checkOutput("arst_m_pw", m_pw, 0);
    checkOutput("arst_m_rs1", m_rs1, 0);
    checkOutput("arst_out_tag", out_tag, 0);
    #2;
    resetn = 1'b1;
    tick();
    checkOutput("arst_rel_in_ready", in_ready, 1);
    checkOutput("arst_rel_m_valid", m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
